// File: rtl/leaderboard_fsm_pkg.sv
// Shared constants and state type for the leaderboard / high-score entry engine.
package leaderboard_fsm_pkg;

    // Character codes used by the virtual keyboard
    localparam int unsigned CHAR_A     = 0;
    localparam int unsigned CHAR_Z     = 25;
    localparam int unsigned CHAR_SPACE = 26;

    // Default field widths
    localparam int unsigned CHAR_SIZE_DEFAULT  = 5;
    localparam int unsigned SCORE_SIZE_DEFAULT = 16;

    // Dancepad one-pulse vector layout
    localparam int unsigned BTN_W        = 8;
    localparam int unsigned BUTTON_UP    = 0;
    localparam int unsigned BUTTON_DOWN  = 1;
    localparam int unsigned BUTTON_LEFT  = 2;
    localparam int unsigned BUTTON_RIGHT = 3;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        NAMING,
        INSERT,
        SHOW
    } lb_state_t;

endpackage

// File: rtl/char_stepper.sv
// Combinational up/down step of one character code with A <-> SPACE wrap.
module char_stepper
    import leaderboard_fsm_pkg::*;
#(
    parameter int unsigned CHAR_SIZE = CHAR_SIZE_DEFAULT
) (
    input  logic [CHAR_SIZE-1:0] ch,
    input  logic                 up,
    input  logic                 down,
    output logic [CHAR_SIZE-1:0] result_c
);

    // UP wins over DOWN; SPACE sits just above Z and just below A
    always_comb begin
        result_c = ch;
        if (up) begin
            result_c = (ch == CHAR_SIZE'(CHAR_SPACE)) ? CHAR_SIZE'(CHAR_A) : ch + CHAR_SIZE'(1);
        end else if (down) begin
            result_c = (ch == CHAR_SIZE'(CHAR_A)) ? CHAR_SIZE'(CHAR_SPACE) : ch - CHAR_SIZE'(1);
        end
    end

endmodule

// File: rtl/leaderboard_fsm.sv
// High-score qualification, name entry and sorted insertion into the leaderboard table.
module leaderboard_fsm
    import leaderboard_fsm_pkg::*;
#(
    parameter  int unsigned DEPTH      = 5,
    parameter  int unsigned NAME_LEN   = 3,
    parameter  int unsigned CHAR_SIZE  = CHAR_SIZE_DEFAULT,
    parameter  int unsigned SCORE_SIZE = SCORE_SIZE_DEFAULT,
    localparam int unsigned RANK_W     = $clog2(DEPTH),
    localparam int unsigned CUR_W      = $clog2(NAME_LEN + 1),
    localparam int unsigned NAME_W     = NAME_LEN * CHAR_SIZE,
    localparam int unsigned ENTRY_W    = NAME_W + SCORE_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [BTN_W-1:0]         btn_pulse,
    input  logic [SCORE_SIZE-1:0]    new_score,
    output logic                     done,
    output logic                     qualified,
    output logic [RANK_W-1:0]        rank,
    output logic [CUR_W-1:0]         cursor,
    output logic [NAME_W-1:0]        name_buf,
    output logic [DEPTH*ENTRY_W-1:0] table_flat
);

    localparam logic [NAME_W-1:0] NAME_ALL_A     = {NAME_LEN{CHAR_SIZE'(CHAR_A)}};
    localparam logic [NAME_W-1:0] NAME_ALL_SPACE = {NAME_LEN{CHAR_SIZE'(CHAR_SPACE)}};

    lb_state_t             state;
    logic [RANK_W-1:0]     idx;
    logic [SCORE_SIZE-1:0] tbl_score [DEPTH];
    logic [NAME_W-1:0]     tbl_name  [DEPTH];

    logic                  btn_up;
    logic                  btn_down;
    logic                  btn_left;
    logic                  btn_right;
    logic                  btn_any;
    logic [CHAR_SIZE-1:0]  cur_char_c;
    logic [CHAR_SIZE-1:0]  stepped_c;
    logic [SCORE_SIZE-1:0] score_above_c;
    logic                  shift_c;
    logic                  at_confirm_c;

    assign btn_up       = btn_pulse[BUTTON_UP];
    assign btn_down     = btn_pulse[BUTTON_DOWN];
    assign btn_left     = btn_pulse[BUTTON_LEFT];
    assign btn_right    = btn_pulse[BUTTON_RIGHT];
    assign btn_any      = |btn_pulse;
    assign at_confirm_c = (cursor >= CUR_W'(NAME_LEN));

    // Character currently under the cursor (char 0 lives in the MSBs)
    always_comb begin
        cur_char_c = CHAR_SIZE'(CHAR_A);
        for (int i = 0; i < NAME_LEN; i++) begin
            if (cursor == CUR_W'(i)) begin
                cur_char_c = name_buf[(NAME_LEN-1-i)*CHAR_SIZE +: CHAR_SIZE];
            end
        end
    end

    char_stepper #(
        .CHAR_SIZE (CHAR_SIZE)
    ) u_char_stepper (
        .ch       (cur_char_c),
        .up       (btn_up),
        .down     (btn_down),
        .result_c (stepped_c)
    );

    // Score of the entry just above the insertion pointer; shift while it is strictly lower
    always_comb begin
        score_above_c = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (idx == RANK_W'(i)) begin
                score_above_c = tbl_score[i-1];
            end
        end
    end

    assign shift_c = (idx != '0) && (score_above_c < new_score);

    // Flattened table, entry 0 in the LSBs
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign table_flat[g*ENTRY_W +: ENTRY_W] = {tbl_name[g], tbl_score[g]};
    end

    // State register, table storage and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            done      <= 1'b0;
            qualified <= 1'b0;
            rank      <= '0;
            cursor    <= '0;
            name_buf  <= NAME_ALL_A;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_score[i] <= '0;
                tbl_name[i]  <= NAME_ALL_SPACE;
            end
        end else if (!en && (state != INSERT)) begin
            state    <= IDLE;
            done     <= 1'b0;
            cursor   <= '0;
            name_buf <= NAME_ALL_A;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    cursor   <= '0;
                    name_buf <= NAME_ALL_A;
                    state    <= CHECK;
                end

                CHECK: begin
                    done <= 1'b0;
                    if (new_score > tbl_score[DEPTH-1]) begin
                        qualified <= 1'b1;
                        state     <= NAMING;
                    end else begin
                        qualified <= 1'b0;
                        state     <= SHOW;
                    end
                end

                NAMING: begin
                    done <= 1'b0;
                    if (!at_confirm_c) begin
                        if (btn_up || btn_down) begin
                            for (int i = 0; i < NAME_LEN; i++) begin
                                if (cursor == CUR_W'(i)) begin
                                    name_buf[(NAME_LEN-1-i)*CHAR_SIZE +: CHAR_SIZE] <= stepped_c;
                                end
                            end
                        end else if (btn_left) begin
                            cursor <= (cursor == '0) ? CUR_W'(NAME_LEN) : cursor - CUR_W'(1);
                        end else if (btn_right) begin
                            cursor <= cursor + CUR_W'(1);
                        end
                    end else begin
                        // On the confirm slot only LEFT edits; any other press commits
                        if (btn_up || btn_down) begin
                            idx   <= RANK_W'(DEPTH - 1);
                            state <= INSERT;
                        end else if (btn_left) begin
                            cursor <= cursor - CUR_W'(1);
                        end else if (btn_any) begin
                            idx   <= RANK_W'(DEPTH - 1);
                            state <= INSERT;
                        end
                    end
                end

                INSERT: begin
                    done <= 1'b0;
                    if (shift_c) begin
                        for (int i = 1; i < DEPTH; i++) begin
                            if (idx == RANK_W'(i)) begin
                                tbl_score[i] <= tbl_score[i-1];
                                tbl_name[i]  <= tbl_name[i-1];
                            end
                        end
                        idx <= idx - RANK_W'(1);
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (idx == RANK_W'(i)) begin
                                tbl_score[i] <= new_score;
                                tbl_name[i]  <= name_buf;
                            end
                        end
                        rank <= idx;
                        if (en) begin
                            state <= SHOW;
                        end else begin
                            state    <= IDLE;
                            cursor   <= '0;
                            name_buf <= NAME_ALL_A;
                        end
                    end
                end

                SHOW: begin
                    done <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaderboard_fsm.sv
// Self-checking bench for leaderboard_fsm with default parameters (DEPTH=5, NAME_LEN=3).
module tb_leaderboard_fsm;

    localparam int unsigned DEPTH      = 5;
    localparam int unsigned NAME_LEN   = 3;
    localparam int unsigned CHAR_SIZE  = 5;
    localparam int unsigned SCORE_SIZE = 16;
    localparam int unsigned NAME_W     = NAME_LEN * CHAR_SIZE;
    localparam int unsigned ENTRY_W    = NAME_W + SCORE_SIZE;
    localparam int unsigned FLAT_W     = DEPTH * ENTRY_W;

    localparam logic [7:0] B_UP    = 8'h01;
    localparam logic [7:0] B_DOWN  = 8'h02;
    localparam logic [7:0] B_LEFT  = 8'h04;
    localparam logic [7:0] B_RIGHT = 8'h08;

    localparam logic [4:0] C_SPACE = 5'd26;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  en = 1'b0;
    logic [7:0]            btn_pulse = '0;
    logic [SCORE_SIZE-1:0] new_score = '0;
    logic                  done;
    logic                  qualified;
    logic [2:0]            rank;
    logic [1:0]            cursor;
    logic [NAME_W-1:0]     name_buf;
    logic [FLAT_W-1:0]     table_flat;

    leaderboard_fsm #(
        .DEPTH      (DEPTH),
        .NAME_LEN   (NAME_LEN),
        .CHAR_SIZE  (CHAR_SIZE),
        .SCORE_SIZE (SCORE_SIZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .btn_pulse  (btn_pulse),
        .new_score  (new_score),
        .done       (done),
        .qualified  (qualified),
        .rank       (rank),
        .cursor     (cursor),
        .name_buf   (name_buf),
        .table_flat (table_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference leaderboard
    logic [SCORE_SIZE-1:0] m_score [DEPTH];
    logic [NAME_W-1:0]     m_name  [DEPTH];

    typedef struct {
        logic [SCORE_SIZE-1:0] score;
        logic [NAME_W-1:0]     name;
        logic [7:0]            confirm;
        logic                  qual;
        logic [2:0]            rank;
    } vec_t;

    typedef struct {
        logic              qual;
        logic [2:0]        rank;
        int                lat;
        logic [FLAT_W-1:0] tbl;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    task automatic check(input string what, input logic [FLAT_W-1:0] act, input logic [FLAT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", what, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_score[i] = '0;
            m_name[i]  = {NAME_LEN{C_SPACE}};
        end
    endtask

    // Place below any equal scores: first slot holding a strictly lower score
    task automatic model_insert(input logic [SCORE_SIZE-1:0] s, input logic [NAME_W-1:0] n);
        int pos;
        pos = DEPTH;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_score[i] < s) pos = i;
        end
        if (pos < DEPTH) begin
            for (int j = DEPTH - 1; j > pos; j--) begin
                m_score[j] = m_score[j-1];
                m_name[j]  = m_name[j-1];
            end
            m_score[pos] = s;
            m_name[pos]  = n;
        end
    endtask

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < DEPTH; i++) begin
            f[i*ENTRY_W +: ENTRY_W] = {m_name[i], m_score[i]};
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        btn_pulse = b;
        tick();
        btn_pulse = '0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            lat++;
        end
        check("done_within_bound", FLAT_W'(done), FLAT_W'(1'b1));
    endtask

    task automatic enter_name(input logic [NAME_W-1:0] n);
        logic [4:0] c;
        for (int i = 0; i < NAME_LEN; i++) begin
            c = n[(NAME_LEN-1-i)*CHAR_SIZE +: CHAR_SIZE];
            if (c == C_SPACE) pulse(B_DOWN);
            else repeat (int'(c)) pulse(B_UP);
            pulse(B_RIGHT);
        end
    endtask

    task automatic run_game(input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        if (v.qual) model_insert(v.score, v.name);
        e.qual = v.qual;
        e.rank = v.rank;
        e.lat  = v.qual ? (DEPTH - 1 - int'(v.rank)) + 2 : 3;
        e.tbl  = model_flat();
        sb.push_back(e);

        new_score = v.score;
        en        = 1'b1;
        tick();
        tick();
        if (v.qual) begin
            enter_name(v.name);
            check("name_entered", FLAT_W'(name_buf), FLAT_W'(v.name));
            check("cursor_at_confirm", FLAT_W'(cursor), FLAT_W'(2'd3));
            pulse(v.confirm);
            wait_done(0, lat);
        end else begin
            wait_done(2, lat);
        end

        got = sb.pop_front();
        check("qualified", FLAT_W'(qualified), FLAT_W'(got.qual));
        if (got.qual) check("rank", FLAT_W'(rank), FLAT_W'(got.rank));
        check("done_latency", FLAT_W'(lat), FLAT_W'(got.lat));
        check("table_after_game", table_flat, got.tbl);

        en = 1'b0;
        tick();
        check("done_cleared_idle", FLAT_W'(done), '0);
        tick();
    endtask

    initial begin
        // score, name {c0,c1,c2}, confirm button, qualified, rank
        vecs[0] = '{16'd0,   {5'd0,  5'd0,  5'd0 }, B_UP,    1'b0, 3'd0};
        vecs[1] = '{16'd100, {5'd2,  5'd0,  5'd0 }, B_UP,    1'b1, 3'd0};
        vecs[2] = '{16'd500, {5'd1,  5'd14, 5'd1 }, 8'h80,   1'b1, 3'd0};
        vecs[3] = '{16'd400, {5'd25, 5'd25, 5'd25}, B_RIGHT, 1'b1, 3'd1};
        vecs[4] = '{16'd300, {C_SPACE, 5'd0, C_SPACE}, B_DOWN, 1'b1, 3'd2};
        vecs[5] = '{16'd200, {5'd3,  5'd4,  5'd5 }, B_UP,    1'b1, 3'd3};
        vecs[6] = '{16'd100, {5'd0,  5'd0,  5'd0 }, B_UP,    1'b0, 3'd0};
        vecs[7] = '{16'd300, {5'd7,  5'd8,  5'd9 }, B_UP,    1'b1, 3'd3};
        vecs[8] = '{16'd200, {5'd0,  5'd0,  5'd0 }, B_UP,    1'b0, 3'd0};
        vecs[9] = '{16'd600, {C_SPACE, 5'd1, C_SPACE}, 8'h10, 1'b1, 3'd0};

        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", FLAT_W'(done), '0);
        check("reset_qualified", FLAT_W'(qualified), '0);
        check("reset_rank", FLAT_W'(rank), '0);
        check("reset_cursor", FLAT_W'(cursor), '0);
        check("reset_name_buf", FLAT_W'(name_buf), '0);
        check("reset_table", table_flat, model_flat());
        rst = 1'b1;
        tick();

        // Editing corner cases, then en dropped mid-NAMING
        new_score = 16'd50;
        en        = 1'b1;
        tick();
        tick();
        check("edit_qualified", FLAT_W'(qualified), FLAT_W'(1'b1));
        check("edit_cursor_start", FLAT_W'(cursor), '0);
        pulse(B_DOWN);
        check("down_on_a_space", FLAT_W'(name_buf), FLAT_W'({C_SPACE, 5'd0, 5'd0}));
        pulse(B_UP);
        check("up_on_space_a", FLAT_W'(name_buf), FLAT_W'({5'd0, 5'd0, 5'd0}));
        pulse(B_UP | B_RIGHT);
        check("up_right_name", FLAT_W'(name_buf), FLAT_W'({5'd1, 5'd0, 5'd0}));
        check("up_right_cursor", FLAT_W'(cursor), '0);
        pulse(B_LEFT);
        check("left_wrap_cursor", FLAT_W'(cursor), FLAT_W'(2'd3));
        en = 1'b0;
        tick();
        check("drop_naming_cursor", FLAT_W'(cursor), '0);
        check("drop_naming_name", FLAT_W'(name_buf), '0);
        check("drop_naming_done", FLAT_W'(done), '0);
        check("drop_naming_qual_held", FLAT_W'(qualified), FLAT_W'(1'b1));
        check("drop_naming_table", table_flat, model_flat());
        tick();

        // Main vector table
        for (int k = 0; k < 10; k++) run_game(vecs[k]);

        // en dropped right after the confirm edge: shift finishes, then IDLE
        new_score = 16'd350;
        en        = 1'b1;
        tick();
        tick();
        enter_name({5'd0, 5'd0, 5'd0});
        btn_pulse = B_UP;
        tick();
        btn_pulse = '0;
        en        = 1'b0;
        model_insert(16'd350, {5'd0, 5'd0, 5'd0});
        tick();
        tick();
        check("drop_insert_rank", FLAT_W'(rank), FLAT_W'(3'd3));
        check("drop_insert_table", table_flat, model_flat());
        check("drop_insert_done", FLAT_W'(done), '0);
        check("drop_insert_cursor", FLAT_W'(cursor), '0);
        repeat (3) tick();
        check("drop_insert_stays_idle", FLAT_W'(done), '0);
        check("drop_insert_table_stable", table_flat, model_flat());

        // Asynchronous reset in the middle of a shift
        new_score = 16'd1000;
        en        = 1'b1;
        tick();
        tick();
        enter_name({5'd0, 5'd0, 5'd0});
        pulse(B_UP);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_insert_table", table_flat, model_flat());
        check("rst_insert_done", FLAT_W'(done), '0);
        check("rst_insert_qualified", FLAT_W'(qualified), '0);
        check("rst_insert_rank", FLAT_W'(rank), '0);
        en = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_table", table_flat, model_flat());
        check("post_rst_done", FLAT_W'(done), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/leaderboard_fsm.md
# leaderboard_fsm

Parametrised high-score entry and leaderboard engine for the scoreboard scene. It owns the ranked score/name table: it checks whether the final score qualifies, runs the virtual-keyboard name entry from dancepad one-pulses, and inserts the entry by a sequential shift. Instantiated in the control core, enabled while the state is SCENE_SCOREBOARD. Its flattened table and entry status feed the scoreboard datagram.

## Interface
Parameters:
- DEPTH, 5: number of leaderboard entries (2..16).
- NAME_LEN, 3: characters per name (1..8).
- CHAR_SIZE, 5: bits per character code.
- SCORE_SIZE, 16: score width, unsigned.

Ports:
- clk  in  1  design clock (clk_main domain).
- rst  in  1  asynchronous, active-low reset; clears the table and FSM.
- en  in  1  scene enable; low returns the FSM to IDLE.
- btn_pulse  in  8  single-cycle button pulses, using BUTTON_UP/DOWN/LEFT/RIGHT indices; bits 7:4 count only as "any button".
- new_score  in  SCORE_SIZE  final game score; sampled in CHECK.
- done  out  1  high in SHOW.
- qualified  out  1  latched in CHECK: new score beat the last entry.
- rank  out  $clog2(DEPTH)  slot that received the entry; valid while done && qualified.
- cursor  out  $clog2(NAME_LEN+1)  edit position; value NAME_LEN means the confirm slot.
- name_buf  out  NAME_LEN*CHAR_SIZE  name being edited; char 0 in the MSBs.
- table_flat  out  DEPTH*(NAME_LEN*CHAR_SIZE+SCORE_SIZE)  entries as {name,score}; entry DEPTH-1 in the MSBs and entry 0 in the LSBs, matching the existing datagram order.

## Operation
- Character codes: CHAR_A=0 through CHAR_Z=25, then CHAR_SPACE=26.
  - UP: SPACE goes to A, otherwise +1.
  - DOWN: A goes to SPACE, otherwise -1.
- Table is sorted by descending score; entry 0 is the best.
- Reset contents: every score 0, every name all CHAR_SPACE.
- Only rst clears the table. Its contents persist across en cycles.
- States:
  - IDLE: cursor=0, name_buf all CHAR_A, done=0. Goes to CHECK when en=1.
  - CHECK (1 cycle): qualified <= new_score > score[DEPTH-1]. Goes to NAMING if qualified, otherwise to SHOW.
  - NAMING: at most one action per cycle, with priority UP > DOWN > LEFT > RIGHT.
    - If cursor<NAME_LEN: UP/DOWN edit name_buf[cursor].
    - LEFT: cursor-1, wrapping from 0 to NAME_LEN.
    - RIGHT: cursor+1.
    - If cursor==NAME_LEN: LEFT gives cursor-1. Any other set bit of btn_pulse goes to INSERT with idx=DEPTH-1.
  - INSERT: one step per cycle.
    - If idx>0 and score[idx-1] < new_score: entry[idx] <= entry[idx-1], idx-1.
    - Otherwise: entry[idx] <= {name_buf,new_score}, rank <= idx, go to SHOW.
    - Ties place the new entry below existing equal scores.
  - SHOW: done=1. Stays until en=0.
- en=0 in any state except INSERT: go to IDLE on the next edge. qualified and rank are held.
- INSERT is atomic. en is ignored until the write step completes, then IDLE is entered if en=0.
- new_score must be stable from CHECK through INSERT. The block does not latch it.

## Timing
- All outputs are registered.
- Reset values: done=0, qualified=0, rank=0, cursor=0, name_buf all CHAR_A, table as defined above, state IDLE.
- en rising to CHECK: 1 cycle. CHECK to SHOW when not qualified: 1 cycle, so done rises on the 3rd edge after en.
- Confirm pulse to done: k+2 edges, where k = DEPTH-1-rank is the number of shift steps (max DEPTH+1).
- A button pulse acts on the edge where it is sampled. The edit is visible on name_buf the following cycle.
- An asynchronous rst assertion mid-INSERT aborts immediately. The table returns to reset contents, so no partial entry remains.

## Structure
- Shared package typedefs.svh/constants.svh holds:
  - CHAR_A, CHAR_Z, CHAR_SPACE, CHAR_SIZE.
  - BUTTON_* indices, SCORE_SIZE.
  - typedef enum LbState {IDLE, CHECK, NAMING, INSERT, SHOW}.
- One natural sub-module, `char_stepper`: combinational up/down character wrap. Used once per cursor write.
- The table is a DEPTH-entry register array, with no RAM inference.

## Test plan
- Reset then en=1, new_score=0: done rises on the 3rd edge, qualified=0, table all scores 0 / names SPACE.
- en=1, new_score=100; UP×2, RIGHT×3, confirm with btnU: entry 0 = {"CAA",100}, rank=0, done after 2+4 cycles (DEPTH=5).
- Scores 500,400,300,200,100 loaded; new_score=300: inserted at rank 3 below the existing 300; old 200 moves to slot 4; 100 is dropped.
- Scores 500,400,300,200,100 loaded; new_score=100: tie does not qualify; the table is unchanged.
- Editing:
  - DOWN on A gives SPACE; UP on SPACE gives A.
  - LEFT at cursor 0 gives cursor=3.
  - UP and RIGHT pulsed in the same cycle: only UP applies.
- Mid-operation events:
  - Drop en mid-NAMING: back to IDLE, table unchanged.
  - Drop en mid-INSERT: the shift completes, then IDLE.
  - Assert rst mid-INSERT: table fully cleared.
